// File: rtl/instr_fetch_if.sv
// instr_fetch_if: host control, instruction-memory and core-side signals of the fetch stage.
interface instr_fetch_if #(parameter int ADDR_W = 8);
  logic start, stop, stall, imem_req, instr_valid, busy, done;
  logic [ADDR_W:0] prog_len, pc;
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0] imem_rdata, instr;
  modport slave (
    input start, stop, prog_len, stall, imem_rdata,
    output imem_req, imem_addr, instr_valid, instr, busy, done, pc
  );
  modport master (
    output start, stop, prog_len, stall, imem_rdata,
    input imem_req, imem_addr, instr_valid, instr, busy, done, pc
  );
endinterface

// File: rtl/instr_fetch.sv
// instr_fetch: walks a pc over a 1-cycle-latency imem and feeds the core through a small FIFO.
// Define IFETCH_LOOP_EN to wrap pc back to 0 after len-1 and fetch until stop.
module instr_fetch #(
  parameter int ADDR_W = 8,
  parameter int DEPTH = 4
) (
  input logic i_clock,
  input logic i_reset_n,
  instr_fetch_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [ADDR_W:0] ONE = 1;
`ifdef IFETCH_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
  state_t r_state, w_state_nx;
  logic [ADDR_W:0] r_pc, r_len;
  logic [CW-1:0] r_cnt;
  logic [PW-1:0] r_wptr, r_rptr;
  logic [15:0] r_fifo [DEPTH];
  logic r_inflight, r_zdone;
  logic w_pop, w_credit, w_issue, w_last, w_accept, w_done;
  always_comb begin
    w_state_nx = r_state;
    w_issue = 1'b0;
    w_done = 1'b0;
    w_accept = (r_state == IDLE) & bus.start & !bus.stop;
    w_pop = (r_cnt != '0) & !bus.stall;
    // The word returning this cycle is already counted by r_inflight.
    w_credit = ({1'b0, r_cnt} + (CW+1)'(r_inflight) - (CW+1)'(w_pop)) < (CW+1)'(DEPTH);
    w_last = (r_pc + ONE) == r_len;
    case (r_state)
      IDLE: w_state_nx = (w_accept && bus.prog_len != '0) ? FETCH : IDLE;
      FETCH: begin
        w_issue = (r_pc < r_len) & w_credit & !bus.stop;
        w_state_nx = (w_issue && w_last && !LOOP) ? DRAIN : FETCH;
      end
      DRAIN: begin
        w_done = !r_inflight && r_cnt == '0 && !bus.stop;
        w_state_nx = (!r_inflight && r_cnt == '0) ? IDLE : DRAIN;
      end
      default: w_state_nx = IDLE;
    endcase
    if (bus.stop) w_state_nx = IDLE;
  end
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= IDLE;
      r_pc <= '0;
      r_len <= '0;
      r_cnt <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
      r_inflight <= 1'b0;
      r_zdone <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_zdone <= w_accept & (bus.prog_len == '0);
      r_inflight <= w_issue;
      r_pc <= (bus.stop | w_accept | (w_issue & LOOP & w_last)) ? '0 : w_issue ? r_pc + ONE : r_pc;
      if (w_accept) r_len <= bus.prog_len;
      if (bus.stop) begin
        r_cnt <= '0;
        r_wptr <= '0;
        r_rptr <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(r_inflight) - CW'(w_pop);
        r_wptr <= r_wptr + PW'(r_inflight);
        r_rptr <= r_rptr + PW'(w_pop);
      end
    end
  end
  always_ff @(posedge i_clock) begin
    if (r_inflight) r_fifo[r_wptr] <= bus.imem_rdata;
  end
  assign bus.imem_req = w_issue;
  assign bus.imem_addr = r_pc[ADDR_W-1:0];
  assign bus.instr_valid = w_pop;
  assign bus.instr = (r_cnt != '0) ? r_fifo[r_rptr] : '0;
  assign bus.busy = r_state != IDLE;
  assign bus.done = w_done | r_zdone;
  assign bus.pc = r_pc;
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: scoreboard bench for instr_fetch with a synchronous 1-cycle instruction memory model.
module tb_instr_fetch;
  localparam int AW = 8;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  logic [15:0] mem [256];
  logic [15:0] q [$];
  always #5 clk = ~clk;
  instr_fetch_if #(.ADDR_W(AW)) bus ();
  instr_fetch #(.ADDR_W(AW), .DEPTH(DEPTH)) dut (.i_clock(clk), .i_reset_n(rst_n), .bus(bus.slave));
  always @(posedge clk) if (bus.imem_req) bus.imem_rdata <= mem[bus.imem_addr];

  task automatic run_prog(input int len, input int st_lo, input int st_hi, input int rs_cyc,
                          output logic [63:0] req_m, output logic [63:0] val_m,
                          output int done_cyc, output int issued, output logic [AW:0] pc_rs);
    int consumed;
    int c;
    logic [15:0] exp;
    req_m = '0; val_m = '0; done_cyc = -1; issued = 0; consumed = 0; pc_rs = '0;
    for (int i = 0; i < len; i++) q.push_back(mem[i]);
    @(negedge clk);
    bus.start = 1'b1; bus.prog_len = (AW+1)'(len); bus.stall = 1'b0;
    #1;
    for (c = 1; c < 300 && done_cyc < 0; c++) begin
      @(negedge clk);
      bus.start = (c == rs_cyc);
      if (c == rs_cyc) bus.prog_len = 1;
      bus.stall = (c >= st_lo && c <= st_hi);
      #1;
      if (c == rs_cyc + 1) pc_rs = bus.pc;
      n_chk++;
      if (bus.pc !== (AW+1)'(issued)) begin n_fail++; $display("FAIL pc c%0d: got %0d want %0d", c, bus.pc, issued); end
      if (bus.imem_req) begin
        if (c < 64) req_m[c] = 1'b1;
        n_chk++;
        if (bus.imem_addr !== AW'(issued)) begin n_fail++; $display("FAIL imem_addr c%0d: got %0d want %0d", c, bus.imem_addr, issued); end
        issued++;
      end
      if (bus.instr_valid) begin
        if (c < 64) val_m[c] = 1'b1;
        consumed++;
        n_chk++;
        if (q.size() == 0) begin n_fail++; $display("FAIL sb_extra c%0d: got %h want none", c, bus.instr); end
        else begin
          exp = q.pop_front();
          if (bus.instr !== exp) begin n_fail++; $display("FAIL sb_instr c%0d: got %h want %h", c, bus.instr, exp); end
        end
      end
      n_chk++;
      if (bus.stall && bus.instr_valid) begin n_fail++; $display("FAIL valid_in_stall c%0d: got 1 want 0", c); end
      n_chk++;
      if (issued - consumed > DEPTH) begin n_fail++; $display("FAIL credit c%0d: got %0d want <=%0d", c, issued - consumed, DEPTH); end
      if (bus.done) done_cyc = c;
    end
    bus.stall = 1'b0;
    n_chk++;
    if (done_cyc < 0) begin n_fail++; $display("FAIL done_timeout: got none want pulse"); end
    n_chk++;
    if (q.size() != 0) begin n_fail++; $display("FAIL sb_left: got %0d words left want 0", q.size()); end
    q.delete();
    @(negedge clk);
    #1;
    n_chk++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_fail++; $display("FAIL post_done: got busy=%b done=%b want 0 0", bus.busy, bus.done); end
  endtask

  task automatic test_reset;
    bus.start = 1'b0; bus.stop = 1'b0; bus.stall = 1'b0; bus.prog_len = '0;
    repeat (2) @(negedge clk);
    #1;
    n_chk++;
    if ({bus.imem_req, bus.instr_valid, bus.busy, bus.done} !== 4'b0) begin n_fail++; $display("FAIL reset_ctl: got %b want 0000", {bus.imem_req, bus.instr_valid, bus.busy, bus.done}); end
    n_chk++;
    if (bus.instr !== 16'h0) begin n_fail++; $display("FAIL reset_instr: got %h want 0000", bus.instr); end
    n_chk++;
    if (bus.pc !== '0) begin n_fail++; $display("FAIL reset_pc: got %0d want 0", bus.pc); end
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    n_chk++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset: got busy=%b done=%b want 0 0", bus.busy, bus.done); end
  endtask

  task automatic test_basic;
    logic [63:0] rm, vm;
    int dc, iss;
    logic [AW:0] p;
    run_prog(3, -1, -1, -1, rm, vm, dc, iss, p);
    n_chk++;
    if (rm !== 64'h0E) begin n_fail++; $display("FAIL basic_req_cycles: got %h want 0e", rm); end
    n_chk++;
    if (vm !== 64'h38) begin n_fail++; $display("FAIL basic_valid_cycles: got %h want 38", vm); end
    n_chk++;
    if (dc != 6) begin n_fail++; $display("FAIL basic_done_cycle: got %0d want 6", dc); end
  endtask

  task automatic test_stall;
    logic [63:0] rm, vm;
    int dc, iss;
    logic [AW:0] p;
    run_prog(8, 2, 9, -1, rm, vm, dc, iss, p);
    n_chk++;
    if (iss != 8) begin n_fail++; $display("FAIL stall_issued: got %0d want 8", iss); end
    n_chk++;
    if (rm[9:0] !== 10'h01E) begin n_fail++; $display("FAIL stall_req_cycles: got %h want 01e", rm[9:0]); end
    n_chk++;
    if (vm[10:0] !== 11'h400) begin n_fail++; $display("FAIL stall_first_valid: got %h want 400", vm[10:0]); end
  endtask

  task automatic test_zero_len;
    @(negedge clk);
    bus.start = 1'b1; bus.prog_len = '0;
    #1;
    @(negedge clk);
    bus.start = 1'b0;
    #1;
    n_chk++;
    if ({bus.done, bus.busy, bus.imem_req} !== 3'b100) begin n_fail++; $display("FAIL zero_len: got done,busy,req=%b want 100", {bus.done, bus.busy, bus.imem_req}); end
    @(negedge clk);
    #1;
    n_chk++;
    if (bus.done !== 1'b0) begin n_fail++; $display("FAIL zero_len_pulse: got %b want 0", bus.done); end
  endtask

  task automatic test_stop;
    @(negedge clk);
    bus.start = 1'b1; bus.prog_len = 9'd6;
    #1;
    @(negedge clk);
    bus.start = 1'b0;
    #1;
    n_chk++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'd0) begin n_fail++; $display("FAIL stop_first_req: got %b/%0d want 1/0", bus.imem_req, bus.imem_addr); end
    @(negedge clk);
    @(negedge clk);
    bus.stop = 1'b1;
    #1;
    n_chk++;
    if (bus.done !== 1'b0) begin n_fail++; $display("FAIL stop_done: got %b want 0", bus.done); end
    for (int c = 4; c < 8; c++) begin
      @(negedge clk);
      bus.stop = 1'b0;
      #1;
      n_chk++;
      if ({bus.busy, bus.instr_valid, bus.imem_req, bus.done} !== 4'b0) begin n_fail++; $display("FAIL after_stop c%0d: got %b want 0000", c, {bus.busy, bus.instr_valid, bus.imem_req, bus.done}); end
      n_chk++;
      if (bus.pc !== '0 || bus.instr !== 16'h0) begin n_fail++; $display("FAIL after_stop_state c%0d: got pc=%0d instr=%h want 0 0000", c, bus.pc, bus.instr); end
    end
  endtask

  task automatic test_start_stop;
    logic [63:0] rm, vm;
    int dc, iss;
    logic [AW:0] p;
    @(negedge clk);
    bus.start = 1'b1; bus.stop = 1'b1; bus.prog_len = 9'd5;
    #1;
    for (int c = 1; c < 3; c++) begin
      @(negedge clk);
      bus.start = 1'b0; bus.stop = 1'b0;
      #1;
      n_chk++;
      if ({bus.busy, bus.imem_req, bus.done} !== 3'b0) begin n_fail++; $display("FAIL start_stop c%0d: got %b want 000", c, {bus.busy, bus.imem_req, bus.done}); end
    end
    run_prog(4, -1, -1, 2, rm, vm, dc, iss, p);
    n_chk++;
    if (p !== 9'd2) begin n_fail++; $display("FAIL restart_pc: got %0d want 2", p); end
    n_chk++;
    if (iss != 4) begin n_fail++; $display("FAIL restart_issued: got %0d want 4", iss); end
  endtask

`ifdef IFETCH_LOOP_EN
  task automatic test_loop;
    int k = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.prog_len = 9'd2;
    #1;
    for (int c = 1; c < 40; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      #1;
      if (bus.instr_valid) begin
        n_chk++;
        if (bus.instr !== mem[k % 2]) begin n_fail++; $display("FAIL loop_instr #%0d: got %h want %h", k, bus.instr, mem[k % 2]); end
        k++;
      end
      n_chk++;
      if (bus.done !== 1'b0) begin n_fail++; $display("FAIL loop_done c%0d: got 1 want 0", c); end
    end
    n_chk++;
    if (k < 30) begin n_fail++; $display("FAIL loop_count: got %0d want >=30", k); end
    @(negedge clk);
    bus.stop = 1'b1;
    #1;
    @(negedge clk);
    bus.stop = 1'b0;
    #1;
    n_chk++;
    if (bus.busy !== 1'b0 || bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL loop_stop: got busy=%b valid=%b want 0 0", bus.busy, bus.instr_valid); end
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'(i * 16'h0313 + 16'h0A5C);
    mem[0] = 16'h1123; mem[1] = 16'h2456; mem[2] = 16'h9A0F;
    test_reset();
`ifndef IFETCH_LOOP_EN
    test_basic();
    test_stall();
`endif
    test_zero_len();
    test_stop();
`ifndef IFETCH_LOOP_EN
    test_start_stop();
`else
    test_loop();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
